// File: rtl/lsu_pkg.sv
// Shared types for the MEM-stage load/store unit: FSM states, the latched op record,
// default geometry and a byte-padding helper.
package lsu_pkg;

  localparam int LSU_WIDTH   = 16;
  localparam int LSU_TAGW    = 4;
  localparam int LSU_RAMSIZE = 4096;
  localparam int DATA_LIMIT  = 3 * LSU_RAMSIZE;

  typedef enum logic [1:0] {
    IDLE,
    ACC0,
    ACC1,
    RESP
  } lsu_state_t;

  typedef struct packed {
    logic                 load;
    logic                 store;
    logic                 half;
    logic                 is_signed;
    logic [LSU_WIDTH-1:0] addr;
    logic [LSU_WIDTH-1:0] wdata;
    logic [LSU_TAGW-1:0]  tag;
  } lsu_op_t;

  // The data segment is byte-wide; the upper bits of a write word are always zero.
  function automatic logic [LSU_WIDTH-1:0] pad_byte(input logic [7:0] b);
    return {{(LSU_WIDTH-8){1'b0}}, b};
  endfunction

endpackage

// File: rtl/lsu_extend.sv
// Load result formatting: merges little-endian bytes of a half load, or zero/sign
// extends a byte load.
module lsu_extend
  import lsu_pkg::*;
#(
  parameter int WIDTH = LSU_WIDTH
) (
  input  logic [7:0]       lo,
  input  logic [7:0]       hi,
  input  logic             half,
  input  logic             is_signed,
  output logic [WIDTH-1:0] data
);

  always_comb begin
    data = '0;
    if (half) begin
      data[15:0] = {hi, lo};
    end else begin
      data[7:0] = lo;
      if (is_signed) begin
        data[WIDTH-1:8] = {(WIDTH-8){lo[7]}};
      end
    end
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: one op at a time, 16-bit accesses split into two byte accesses.
// Optional address range fault checking is enabled by defining LSU_RANGE_CHECK_EN.
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int WIDTH   = LSU_WIDTH,
  parameter int TAGW    = LSU_TAGW,
  parameter int RAMSIZE = LSU_RAMSIZE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_load,
  input  logic             in_store,
  input  logic             in_half,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] in_addr,
  input  logic [WIDTH-1:0] in_wdata,
  input  logic [TAGW-1:0]  in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAGW-1:0]  out_tag,
  output logic             out_wb,
  output logic             out_fault,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wd,
  input  logic [WIDTH-1:0] mem_rd
);

  lsu_state_t       state;
  lsu_op_t          op_reg;
  logic [7:0]       lo_reg;
  logic             accept;
  logic             in_st;
  logic             in_ld;
  logic             in_mem;
  logic             in_fault;
  logic [7:0]       lo_byte;
  logic [WIDTH-1:0] load_data;
  logic             unused_rd;

  assign in_ready = (state == IDLE) & ~reset;
  assign accept   = in_valid & in_ready;
  assign in_st    = in_store;
  assign in_ld    = in_load & ~in_store;
  assign in_mem   = in_st | in_ld;

  // Only the low byte of the read port carries data.
  assign unused_rd = ^mem_rd[WIDTH-1:8];

`ifdef LSU_RANGE_CHECK_EN
  localparam logic [WIDTH:0] LIMIT = (WIDTH+1)'(3 * RAMSIZE);
  logic [WIDTH-1:0] in_addr_p1;
  assign in_addr_p1 = in_addr + WIDTH'(1);
  // addr+1 wraps at 2^WIDTH, so the second byte of a half op can fault on its own.
  assign in_fault = in_mem & (({1'b0, in_addr} >= LIMIT) |
                              (in_half & ({1'b0, in_addr_p1} >= LIMIT)));
`else
  assign in_fault = 1'b0;
`endif

  // In ACC0 the low byte is still on the bus; a byte load finishes on this edge.
  assign lo_byte = (state == ACC0) ? mem_rd[7:0] : lo_reg;

  lsu_extend #(.WIDTH(WIDTH)) u_extend (
    .lo        (lo_byte),
    .hi        (mem_rd[7:0]),
    .half      (op_reg.half),
    .is_signed (op_reg.is_signed),
    .data      (load_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      op_reg    <= '0;
      lo_reg    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
      out_wb    <= 1'b0;
      out_fault <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wd    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_reg <= '{load: in_ld, store: in_st, half: in_half, is_signed: in_signed,
                        addr: in_addr, wdata: in_wdata, tag: in_tag};
            if (!in_mem || in_fault) begin
              state     <= RESP;
              out_valid <= 1'b1;
              out_tag   <= in_tag;
              out_data  <= in_mem ? '0 : in_wdata;
              out_wb    <= ~in_mem;
              out_fault <= in_fault;
            end else begin
              state    <= ACC0;
              mem_addr <= in_addr;
              mem_we   <= in_st;
              mem_wd   <= in_st ? pad_byte(in_wdata[7:0]) : '0;
            end
          end
        end
        ACC0: begin
          lo_reg <= mem_rd[7:0];
          if (op_reg.half) begin
            state    <= ACC1;
            mem_addr <= op_reg.addr + WIDTH'(1);
            mem_we   <= op_reg.store;
            mem_wd   <= op_reg.store ? pad_byte(op_reg.wdata[15:8]) : '0;
          end else begin
            state     <= RESP;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wd    <= '0;
            out_valid <= 1'b1;
            out_tag   <= op_reg.tag;
            out_data  <= op_reg.load ? load_data : '0;
            out_wb    <= op_reg.load;
            out_fault <= 1'b0;
          end
        end
        ACC1: begin
          state     <= RESP;
          mem_we    <= 1'b0;
          mem_addr  <= '0;
          mem_wd    <= '0;
          out_valid <= 1'b1;
          out_tag   <= op_reg.tag;
          out_data  <= op_reg.load ? load_data : '0;
          out_wb    <= op_reg.load;
          out_fault <= 1'b0;
        end
        RESP: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_tag   <= '0;
            out_wb    <= 1'b0;
            out_fault <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed scenarios then random ops against a
// byte-array reference model. Honors LSU_RANGE_CHECK_EN when defined.
module tb_mem_stage_lsu;

  localparam int LIM = 3 * 4096;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_load, in_store, in_half, in_signed;
  logic [15:0] in_addr, in_wdata;
  logic [3:0]  in_tag;
  logic        out_valid, out_ready, out_wb, out_fault;
  logic [15:0] out_data;
  logic [3:0]  out_tag;
  logic        mem_we;
  logic [15:0] mem_addr, mem_wd, mem_rd;

  logic [7:0]  tb_mem  [0:65535];
  logic [7:0]  ref_mem [0:65535];
  logic [23:0] wr_q[$];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_stage_lsu dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_load(in_load), .in_store(in_store),
    .in_half(in_half), .in_signed(in_signed), .in_addr(in_addr), .in_wdata(in_wdata),
    .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
    .out_wb(out_wb), .out_fault(out_fault),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  // Byte-wide data segment seen by the DUT.
  assign mem_rd = {8'h00, tb_mem[mem_addr]};
  always @(posedge clk) begin
    if (mem_we) begin
      tb_mem[mem_addr] <= mem_wd[7:0];
      wr_q.push_back({mem_addr, mem_wd[7:0]});
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit range_fault(input bit mem, input bit half, input logic [15:0] a);
`ifdef LSU_RANGE_CHECK_EN
    logic [15:0] a1;
    a1 = a + 16'd1;
    return mem && ((int'(a) >= LIM) || (half && int'(a1) >= LIM));
`else
    return 1'b0 & mem & half & a[0];
`endif
  endfunction

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    tb_mem[a]  = d;
    ref_mem[a] = d;
  endtask

  // One complete transaction: issue, wait for result, optional back-pressure, retire.
  task automatic do_op(input bit ld, input bit st, input bit half, input bit sgn,
                       input logic [15:0] addr, input logic [15:0] wdata,
                       input logic [3:0] tag, input int hold);
    bit          mem, flt, exp_wb;
    int          exp_lat, lat, n;
    logic [15:0] exp_data, a1;
    logic [7:0]  b;
    logic [23:0] exp_w[$];
    mem = ld || st;
    a1  = addr + 16'd1;
    flt = range_fault(mem, half, addr);
    exp_data = 16'h0;
    exp_wb   = 1'b0;
    if (!mem) begin
      exp_lat = 1; exp_data = wdata; exp_wb = 1'b1;
    end else if (flt) begin
      exp_lat = 1;
    end else begin
      exp_lat = half ? 3 : 2;
      if (st) begin
        exp_w.push_back({addr, wdata[7:0]});
        ref_mem[addr] = wdata[7:0];
        if (half) begin
          exp_w.push_back({a1, wdata[15:8]});
          ref_mem[a1] = wdata[15:8];
        end
      end else begin
        exp_wb = 1'b1;
        b = ref_mem[addr];
        if (half) exp_data = {ref_mem[a1], b};
        else      exp_data = sgn ? {{8{b[7]}}, b} : {8'h00, b};
      end
    end

    @(negedge clk);
    n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    check("in_ready_idle", in_ready, 1);
    wr_q.delete();
    in_valid = 1'b1; in_load = ld; in_store = st; in_half = half; in_signed = sgn;
    in_addr = addr; in_wdata = wdata; in_tag = tag;
    out_ready = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin @(negedge clk); lat++; end
    check("latency", lat, exp_lat);
    check("out_data", out_data, exp_data);
    check("out_wb", out_wb, exp_wb);
    check("out_tag", out_tag, tag);
    check("out_fault", out_fault, flt);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_data", out_data, exp_data);
      check("hold_in_ready", in_ready, 0);
      check("hold_mem_we", mem_we, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("retired", out_valid, 0);
    check("write_count", wr_q.size(), exp_w.size());
    for (int i = 0; i < exp_w.size() && i < wr_q.size(); i++)
      check("write_entry", wr_q[i], exp_w[i]);
    $display("op ld=%0d st=%0d half=%0d sgn=%0d addr=%h wdata=%h tag=%h -> data=%h wb=%0d fault=%0d lat=%0d",
             ld, st, half, sgn, addr, wdata, tag, out_data, exp_wb, flt, lat);
  endtask

  initial begin
    logic [15:0] a, w;
    int          k;
    for (int i = 0; i < 65536; i++) begin
      w = 16'($urandom);
      tb_mem[i]  = w[7:0];
      ref_mem[i] = w[7:0];
    end
    reset = 1'b1; in_valid = 1'b0; in_load = 1'b0; in_store = 1'b0; in_half = 1'b0;
    in_signed = 1'b0; in_addr = '0; in_wdata = '0; in_tag = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);

    // Half store, byte loads, cross-bank half load, back-pressure, non-memory op.
    do_op(0, 1, 1, 0, 16'h0010, 16'hBEEF, 4'h1, 0);
    poke(16'h1000, 8'h9C);
    do_op(1, 0, 0, 0, 16'h1000, 16'h0000, 4'h2, 0);
    do_op(1, 0, 0, 1, 16'h1000, 16'h0000, 4'h3, 0);
    poke(16'h2FFF, 8'h34);
    poke(16'h3000, 8'h12);
    do_op(1, 0, 1, 0, 16'h2FFF, 16'h0000, 4'h4, 0);
    do_op(1, 0, 1, 0, 16'h0010, 16'h0000, 4'h5, 5);
    do_op(0, 0, 0, 0, 16'h0000, 16'h5A5A, 4'h6, 2);

    // Reset while the high byte of a half store is on the bus.
    @(negedge clk);
    wr_q.delete();
    in_valid = 1'b1; in_load = 1'b0; in_store = 1'b1; in_half = 1'b1; in_signed = 1'b0;
    in_addr = 16'h0400; in_wdata = 16'hA55A; in_tag = 4'h7;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("acc1_mem_we", mem_we, 1);
    check("acc1_mem_addr", mem_addr, 16'h0401);
    reset = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_out_tag", out_tag, 0);
    check("midrst_out_wb", out_wb, 0);
    check("midrst_out_fault", out_fault, 0);
    check("midrst_mem_we", mem_we, 0);
    check("midrst_mem_addr", mem_addr, 0);
    check("midrst_mem_wd", mem_wd, 0);
    check("midrst_in_ready", in_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    ref_mem[16'h0400] = 8'h5A;
    check("midrst_writes", wr_q.size(), 1);
    if (wr_q.size() > 0) check("midrst_low_byte", wr_q[0], {16'h0400, 8'h5A});
    $display("reset in ACC1 of half store at 0400: writes=%0d", wr_q.size());
    do_op(1, 0, 1, 0, 16'h0400, 16'h0000, 4'h8, 0);

    // Store at the first out-of-range byte, and wrap of the second byte address.
    do_op(0, 1, 0, 0, 16'h3000, 16'h0077, 4'h9, 0);
    do_op(1, 0, 1, 0, 16'hFFFF, 16'h0000, 4'hA, 1);
    do_op(0, 1, 1, 0, 16'h2FFF, 16'hC3D2, 4'hB, 0);
    do_op(1, 1, 0, 0, 16'h0020, 16'h00E1, 4'hC, 0);

    for (int i = 0; i < 60; i++) begin
      k = $urandom_range(0, 3);
      a = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, LIM - 1));
      if ($urandom_range(0, 1) == 0) a = a & 16'h00FF;
      w = 16'($urandom);
      do_op(k[0], k[1], 1'($urandom), 1'($urandom), a, w, 4'($urandom),
            $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
